// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU and its iterative mul/div unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_DIVU = 4'd6;
  localparam logic [3:0] ALU_REMU = 4'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle.
// opa holds multiplicand / dividend-then-quotient, opb holds multiplier / divisor, acc holds product / remainder.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] opa_next
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  // The subtraction is only kept when rem_shift >= divisor, so the true difference fits in WIDTH bits.
  always_comb begin
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opb_q};
    rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    if (start) begin
      acc_d = '0;
      opa_d = a;
      opb_d = b;
    end else if (step) begin
      if (is_div) begin
        acc_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], rem_ge};
      end else begin
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign acc_next = acc_d;
  assign opa_next = opa_d;

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU with valid/ready handshakes, carry/overflow flags and optional iterative MUL/DIVU/REMU.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit HAS_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       f_q, f_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, c_q, c_d, v_q, v_d;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] sc_y;
  logic             sc_c, sc_v;
  logic             iter_start, iter_step, iter_is_div;
  logic [WIDTH-1:0] acc_next, opa_next, iter_res;

  // Single-cycle result, computed straight from the inputs so it can be captured on the acceptance edge.
  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    sc_y   = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (f)
      ALU_ADD: begin
        sc_y = sum_w[WIDTH-1:0];
        sc_c = sum_w[WIDTH];
        sc_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_y = diff_w[WIDTH-1:0];
        sc_c = diff_w[WIDTH];
        sc_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: sc_y = a & b;
      ALU_OR:  sc_y = a | b;
      ALU_XOR: sc_y = a ^ b;
      default: sc_y = '0;
    endcase
  end

  generate
    if (HAS_MULDIV) begin : g_muldiv
      alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rstn     (rstn),
        .start    (iter_start),
        .step     (iter_step),
        .is_div   (iter_is_div),
        .a        (a),
        .b        (b),
        .acc_next (acc_next),
        .opa_next (opa_next)
      );
    end else begin : g_no_muldiv
      assign acc_next = '0;
      assign opa_next = '0;
    end
  endgenerate

  assign iter_is_div = (f_q == ALU_DIVU) || (f_q == ALU_REMU);
  assign iter_res    = (f_q == ALU_DIVU) ? opa_next : acc_next;

  // Handshake FSM; the last BUSY step's result is captured in the same edge that enters DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f_d        = f_q;
    y_d        = y_q;
    z_d        = z_q;
    c_d        = c_q;
    v_d        = v_q;
    iter_start = 1'b0;
    iter_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          f_d = f;
          if (HAS_MULDIV && is_iter_op(f)) begin
            state_d    = S_BUSY;
            cnt_d      = CNT_LOAD;
            iter_start = 1'b1;
          end else begin
            state_d = S_DONE;
            y_d     = sc_y;
            z_d     = (sc_y == '0);
            c_d     = sc_c;
            v_d     = sc_v;
          end
        end
      end
      S_BUSY: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          y_d     = iter_res;
          z_d     = (iter_res == '0);
          c_d     = 1'b0;
          v_d     = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign z         = z_q;
  assign c         = c_q;
  assign v         = v_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed-vector bench for alu_seq_muldiv at WIDTH=8, plus a HAS_MULDIV=0 instance sharing operands.
module tb_alu_seq_muldiv;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_DIVU = 4'd6;
  localparam logic [3:0] OP_REMU = 4'd7;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] f;
  logic       z, c, v;
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0] y2;
  logic       z2, c2, v2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(8), .HAS_MULDIV(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .z(z), .c(c), .v(v)
  );

  alu_seq_muldiv #(.WIDTH(8), .HAS_MULDIV(1'b0)) dut_nomd (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .f(f), .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .z(z2), .c(c2), .v(v2)
  );

  // Presents one op for a single edge, then scrambles the operands so later changes must be ignored.
  task automatic send(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    f = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'h5A; b = 8'hC3; f = OP_AND;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b, want 0", out_valid); end
    tests_run++;
    if ({y, z, c, v} !== 11'h000) begin
      tests_failed++; $display("[TB] FAIL reset_outputs: got y=%h z=%b c=%b v=%b, want all 0", y, z, c, v);
    end
  endtask

  task automatic test_add();
    int n;
    send(OP_ADD, 8'hFF, 8'h01);
    wait_out(n);
    tests_run++;
    if (n !== 1) begin tests_failed++; $display("[TB] FAIL add_latency: got %0d, want 1", n); end
    tests_run++;
    if ({y, z, c, v} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL add_ff_01: got y=%h z=%b c=%b v=%b, want y=00 z=1 c=1 v=0", y, z, c, v);
    end
    consume();
  endtask

  task automatic test_sub();
    int n;
    send(OP_SUB, 8'h80, 8'h01);
    wait_out(n);
    tests_run++;
    if ({y, z, c, v} !== {8'h7F, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL sub_80_01: got y=%h z=%b c=%b v=%b, want y=7f z=0 c=0 v=1", y, z, c, v);
    end
    consume();
    send(OP_SUB, 8'd3, 8'd5);
    wait_out(n);
    tests_run++;
    if ({y, z, c, v} !== {8'hFE, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL sub_3_5: got y=%h z=%b c=%b v=%b, want y=fe z=0 c=1 v=0", y, z, c, v);
    end
    consume();
  endtask

  task automatic test_logic();
    int n;
    send(OP_OR, 8'hA0, 8'h05);
    wait_out(n);
    tests_run++;
    if ({y, z, c, v} !== {8'hA5, 3'b000}) begin
      tests_failed++; $display("[TB] FAIL or_a0_05: got y=%h z=%b c=%b v=%b, want y=a5 z=0 c=0 v=0", y, z, c, v);
    end
    consume();
    send(OP_XOR, 8'hFF, 8'hFF);
    wait_out(n);
    tests_run++;
    if ({y, z} !== {8'h00, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL xor_ff_ff: got y=%h z=%b, want y=00 z=1", y, z);
    end
    consume();
    send(4'd9, 8'hFF, 8'h01);
    wait_out(n);
    tests_run++;
    if ({n[7:0], y, z, c, v} !== {8'd1, 8'h00, 3'b100}) begin
      tests_failed++; $display("[TB] FAIL op9: got n=%0d y=%h z=%b c=%b v=%b, want n=1 y=00 z=1 c=0 v=0", n, y, z, c, v);
    end
    consume();
  endtask

  task automatic test_mul();
    send(OP_MUL, 8'd13, 8'd11);
    for (int k = 1; k <= 9; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== (k == 9)) begin
        tests_failed++;
        $display("[TB] FAIL mul_cycle%0d: got in_ready=%b out_valid=%b, want in_ready=0 out_valid=%b", k, in_ready, out_valid, k == 9);
      end
      if (k < 9) begin @(posedge clk); #1; end
    end
    tests_run++;
    if ({y, z, c, v} !== {8'h8F, 3'b000}) begin
      tests_failed++; $display("[TB] FAIL mul_13_11: got y=%h z=%b c=%b v=%b, want y=8f z=0 c=0 v=0", y, z, c, v);
    end
    consume();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_release: got in_ready=%b, want 1", in_ready); end
  endtask

  task automatic test_div();
    logic [3:0] ops [4];
    logic [7:0] as [4];
    logic [7:0] bs [4];
    logic [7:0] exp [4];
    int n;
    ops = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
    as  = '{8'd100, 8'd100, 8'd100, 8'd42};
    bs  = '{8'd7, 8'd7, 8'd0, 8'd0};
    exp = '{8'd14, 8'd2, 8'hFF, 8'd42};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_out(n);
      tests_run++;
      if (n !== 9 || y !== exp[i] || z !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL div_vec%0d: got n=%0d y=%h z=%b, want n=9 y=%h z=0", i, n, y, z, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    send(OP_AND, 8'hF0, 8'h3C);
    wait_out(n);
    @(negedge clk);
    f = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h30) begin
        tests_failed++;
        $display("[TB] FAIL hold_cycle%0d: got out_valid=%b in_ready=%b y=%h, want 1 0 30", k, out_valid, in_ready, y);
      end
    end
    in_valid = 1'b0;
    consume();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL hold_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    @(negedge clk);
    f = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        tests_run++;
        if (y !== 8'd2) begin tests_failed++; $display("[TB] FAIL b2b_y: got %h, want 02", y); end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (cnt !== 5) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d results, want 5", cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    send(OP_MUL, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || y !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL rst_busy: got out_valid=%b y=%h, want 0 00", out_valid, y);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL rst_after%0d: got out_valid=%b in_ready=%b, want 0 1", k, out_valid, in_ready);
      end
    end
    send(OP_ADD, 8'd2, 8'd3);
    wait_out(n);
    tests_run++;
    if (n !== 1 || y !== 8'd5) begin tests_failed++; $display("[TB] FAIL rst_add: got n=%0d y=%h, want n=1 y=05", n, y); end
    // Leave the result unconsumed and reset while in DONE.
    @(negedge clk) rstn = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || y !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL rst_done: got out_valid=%b y=%h, want 0 00", out_valid, y);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rst_done_after: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_nomd();
    @(negedge clk);
    f = OP_MUL; a = 8'd13; b = 8'd11; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    tests_run++;
    if ({out_valid2, in_ready2, y2, z2, c2, v2} !== {1'b1, 1'b0, 8'h00, 3'b100}) begin
      tests_failed++;
      $display("[TB] FAIL nomd_mul: got out_valid=%b in_ready=%b y=%h z=%b c=%b v=%b, want 1 0 00 1 0 0",
               out_valid2, in_ready2, y2, z2, c2, v2);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL nomd_idle: got out_valid=%b in_ready=%b, want 0 1", out_valid2, in_ready2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    a = 8'h00; b = 8'h00; f = 4'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_nomd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
